// File: rtl/alu_pipe_mc.sv
// rtl/alu_pipe_mc.sv - multi-cycle ALU with operand wait, multiply pipeline and timeout
//
// Purpose: two-operand ALU that accepts operands together or split across
// cycles, runs multiplies over MUL_LAT cycles and flags a missing operand
// after WAIT_MAX enabled cycles.
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_ce (clock enable)
//   i_opa, i_opb (N), i_cin, i_mode (1=arith, 0=logic), i_cmd (M)
//   i_inp_valid[0]=opa valid, [1]=opb valid
//   o_res (2N), o_cout, o_oflow, o_g, o_l, o_e, o_err
//   o_out_valid (one-cycle pulse), o_busy (new inputs ignored)
module alu_pipe_mc #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int MUL_LAT  = 3,
  parameter int WAIT_MAX = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_ce,
  input  logic [N-1:0]   i_opa,
  input  logic [N-1:0]   i_opb,
  input  logic           i_cin,
  input  logic           i_mode,
  input  logic [M-1:0]   i_cmd,
  input  logic [1:0]     i_inp_valid,
  output logic [2*N-1:0] o_res,
  output logic           o_cout,
  output logic           o_oflow,
  output logic           o_g,
  output logic           o_l,
  output logic           o_e,
  output logic           o_err,
  output logic           o_out_valid,
  output logic           o_busy
);
  localparam int LG = $clog2(N);
  localparam int CW = $clog2(WAIT_MAX + MUL_LAT + 1);
  localparam logic [N:0] C_ONE = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_opa, r_opb;
  logic [M-1:0]   r_cmd;
  logic           r_mode, r_cin;
  logic [1:0]     r_have;
  logic [2*N-1:0] r_res;
  logic [5:0]     r_flags;
  logic           r_out_valid, r_busy;

  logic           w_live, w_mode, w_cin;
  logic [M-1:0]   w_cmd;
  logic [31:0]    w_code;
  logic [N-1:0]   w_a, w_b, w_rol, w_ror;
  logic [LG-1:0]  w_amt;
  logic           w_def, w_need_a, w_need_b, w_is_mul, w_arrive;
  logic [1:0]     w_need;
  logic [N:0]     w_t;
  logic [2*N:0]   w_p;
  logic [2*N-1:0] w_res;
  logic           w_cout, w_oflow, w_g, w_l, w_e, w_err;
  logic [5:0]     w_flags;

  // In IDLE the live inputs drive the datapath; otherwise the latched command
  // is used, and an operand comes from the inputs only while it is still missing.
  assign w_live   = (r_state == S_IDLE);
  assign w_mode   = w_live ? i_mode : r_mode;
  assign w_cmd    = w_live ? i_cmd  : r_cmd;
  assign w_cin    = w_live ? i_cin  : r_cin;
  assign w_a      = (w_live || !r_have[0]) ? i_opa : r_opa;
  assign w_b      = (w_live || !r_have[1]) ? i_opb : r_opb;
  assign w_code   = 32'(w_cmd);
  assign w_amt    = w_b[LG-1:0];
  assign w_need   = {w_need_b, w_need_a};
  assign w_arrive = |(i_inp_valid & ~r_have);
  assign w_flags  = {w_err, w_e, w_l, w_g, w_oflow, w_cout};

  always_comb begin
    w_def = 1'b0; w_need_a = 1'b1; w_need_b = 1'b1; w_is_mul = 1'b0;
    if (w_mode) begin
      w_def = (w_code <= 12);
      case (w_code)
        4, 5:    w_need_b = 1'b0;
        6, 7:    w_need_a = 1'b0;
        9, 10:   w_is_mul = 1'b1;
        default: ;
      endcase
    end else begin
      w_def = (w_code <= 13);
      case (w_code)
        6, 8, 9:   w_need_b = 1'b0;
        7, 10, 11: w_need_a = 1'b0;
        default:   ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_rol[i] = w_a[(i + N - int'(w_amt)) % N];
      w_ror[i] = w_a[(i + int'(w_amt)) % N];
    end
  end

  always_comb begin
    w_t = '0; w_p = '0; w_res = '0;
    w_cout = 1'b0; w_oflow = 1'b0; w_g = 1'b0; w_l = 1'b0; w_e = 1'b0; w_err = 1'b0;
    if (w_mode) begin
      case (w_code)
        0, 2: begin
          w_t = {1'b0, w_a} + {1'b0, w_b} + ((w_code == 2) ? {{N{1'b0}}, w_cin} : '0);
          w_res = {{(N-1){1'b0}}, w_t}; w_cout = w_t[N];
        end
        1, 3: begin  // borrow appears as the extra top bit of the difference
          w_t = {1'b0, w_a} - {1'b0, w_b} - ((w_code == 3) ? {{N{1'b0}}, w_cin} : '0);
          w_res = {{N{1'b0}}, w_t[N-1:0]}; w_cout = w_t[N];
        end
        4: begin w_t = {1'b0, w_a} + C_ONE; w_res = {{N{1'b0}}, w_t[N-1:0]}; w_cout = w_t[N]; end
        5: begin w_t = {1'b0, w_a} - C_ONE; w_res = {{N{1'b0}}, w_t[N-1:0]}; w_cout = w_t[N]; end
        6: begin w_t = {1'b0, w_b} + C_ONE; w_res = {{N{1'b0}}, w_t[N-1:0]}; w_cout = w_t[N]; end
        7: begin w_t = {1'b0, w_b} - C_ONE; w_res = {{N{1'b0}}, w_t[N-1:0]}; w_cout = w_t[N]; end
        8: begin w_g = (w_a > w_b); w_l = (w_a < w_b); w_e = (w_a == w_b); end
        9: begin  // (2^N)^2 is the only product reaching bit 2N
          w_p = {{N{1'b0}}, ({1'b0, w_a} + C_ONE)} * {{N{1'b0}}, ({1'b0, w_b} + C_ONE)};
          w_res = w_p[2*N-1:0]; w_oflow = w_p[2*N];
        end
        10: begin
          w_p = {{(N+1){1'b0}}, w_a[N-2:0], 1'b0} * {{(N+1){1'b0}}, w_b};
          w_res = w_p[2*N-1:0];
        end
        11, 12: begin
          w_t = (w_code == 11) ? ({w_a[N-1], w_a} + {w_b[N-1], w_b})
                               : ({w_a[N-1], w_a} - {w_b[N-1], w_b});
          w_res = {{(N-1){w_t[N]}}, w_t};
          w_oflow = w_t[N] ^ w_t[N-1];
          w_g = ($signed(w_a) > $signed(w_b));
          w_l = ($signed(w_a) < $signed(w_b));
          w_e = (w_a == w_b);
        end
        default: w_err = 1'b1;
      endcase
    end else begin
      case (w_code)
        0:  w_res = {{N{1'b0}}, w_a & w_b};
        1:  w_res = {{N{1'b0}}, ~(w_a & w_b)};
        2:  w_res = {{N{1'b0}}, w_a | w_b};
        3:  w_res = {{N{1'b0}}, ~(w_a | w_b)};
        4:  w_res = {{N{1'b0}}, w_a ^ w_b};
        5:  w_res = {{N{1'b0}}, ~(w_a ^ w_b)};
        6:  w_res = {{N{1'b0}}, ~w_a};
        7:  w_res = {{N{1'b0}}, ~w_b};
        8:  w_res = {{N{1'b0}}, 1'b0, w_a[N-1:1]};
        9:  w_res = {{N{1'b0}}, w_a[N-2:0], 1'b0};
        10: w_res = {{N{1'b0}}, 1'b0, w_b[N-1:1]};
        11: w_res = {{N{1'b0}}, w_b[N-2:0], 1'b0};
        12: begin w_res = {{N{1'b0}}, w_rol}; w_err = |w_b[N-1:LG]; end
        13: begin w_res = {{N{1'b0}}, w_ror}; w_err = |w_b[N-1:LG]; end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE; r_cnt <= '0; r_opa <= '0; r_opb <= '0; r_cmd <= '0;
      r_mode <= 1'b0; r_cin <= 1'b0; r_have <= 2'b00; r_res <= '0; r_flags <= '0;
      r_out_valid <= 1'b0; r_busy <= 1'b0;
    end else if (!i_ce) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_inp_valid != 2'b00) begin
          if (w_def && ((i_inp_valid & w_need) == w_need)) begin
            if (w_is_mul) begin
              r_state <= S_MUL; r_busy <= 1'b1; r_cnt <= '0; r_have <= 2'b11;
              r_opa <= i_opa; r_opb <= i_opb; r_cmd <= i_cmd; r_mode <= i_mode; r_cin <= i_cin;
            end else begin
              r_res <= w_res; r_flags <= w_flags; r_out_valid <= 1'b1;
            end
          end else if (w_def && w_need == 2'b11) begin
            // exactly one operand of a two-operand command: hold it and wait
            r_state <= S_WAIT; r_busy <= 1'b1; r_cnt <= '0; r_have <= i_inp_valid;
            r_opa <= i_inp_valid[0] ? i_opa : '0;
            r_opb <= i_inp_valid[1] ? i_opb : '0;
            r_cmd <= i_cmd; r_mode <= i_mode; r_cin <= i_cin;
          end else begin
            r_res <= '0; r_flags <= 6'b100000; r_out_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_arrive) begin
            r_opa <= w_a; r_opb <= w_b; r_have <= 2'b11; r_cnt <= '0;
            if (w_is_mul) begin
              r_state <= S_MUL;
            end else begin
              r_state <= S_IDLE; r_busy <= 1'b0;
              r_res <= w_res; r_flags <= w_flags; r_out_valid <= 1'b1;
            end
          end else if (r_cnt == CW'(WAIT_MAX - 1)) begin
            r_state <= S_IDLE; r_busy <= 1'b0; r_cnt <= '0;
            r_res <= '0; r_flags <= 6'b100000; r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_LAT - 1)) begin
            r_state <= S_IDLE; r_busy <= 1'b0; r_cnt <= '0;
            r_res <= w_res; r_flags <= w_flags; r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin r_state <= S_IDLE; r_busy <= 1'b0; end
      endcase
    end
  end

  assign o_res       = r_res;
  assign {o_err, o_e, o_l, o_g, o_oflow, o_cout} = r_flags;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
endmodule
